// File: rtl/sa_skew_feeder.sv
// Input staging for the systolic PE array.
// Takes one weight vector and one activation vector per accepted beat and skews them
// diagonally: lane n of either operand reaches the array n cycles after lane 0. The
// control FSM sizes each stream from k_len, lets the skew chains drain with zeros once the
// last beat is in, and then pulses done for one cycle.
module sa_skew_feeder #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned INWIDTH = 8,
  parameter int unsigned CNTW    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNTW-1:0]                k_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [COLS-1:0][INWIDTH-1:0]   in_w,
  input  logic [ROWS-1:0][INWIDTH-1:0]   in_a,
  output logic [COLS-1:0][INWIDTH-1:0]   out_w,
  output logic [ROWS-1:0][INWIDTH-1:0]   out_a,
  output logic                           fire,
  output logic                           busy,
  output logic                           done
);

  // The deepest lane needs D extra cycles to empty after the last beat is loaded.
  localparam int unsigned D = ((ROWS > COLS) ? ROWS : COLS) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StFlush,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
  logic            fire_q;
  logic            accept;
  logic            last_beat;
  logic            flush_last;

  // in_ready is decoded from registered state only, so accept never loops back to in_ready.
  assign accept     = in_valid & in_ready;
  assign last_beat  = (beat_cnt_q == CNTW'(1));
  assign flush_last = (flush_cnt_q == CNTW'(D));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (k_len != '0) begin
            beat_cnt_d = k_len;
            state_d    = StFeed;
          end else begin
            // Empty stream: nothing to feed or flush, report completion straight away.
            state_d = StDone;
          end
        end
      end
      StFeed: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q - CNTW'(1);
          if (last_beat) begin
            state_d     = StFlush;
            flush_cnt_d = '0;
          end
        end
      end
      StFlush: begin
        // D+1 flush cycles: the last lane emits the final element in the last of them.
        if (flush_last) begin
          state_d = StDone;
        end else begin
          flush_cnt_d = flush_cnt_q + CNTW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StFeed: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StFlush: begin
        busy = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Fire tracks the head of lane 0, so it is high exactly when lane 0 holds a real beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_q <= 1'b0;
    end else begin
      fire_q <= accept;
    end
  end

  assign fire = fire_q;

  // Weight lanes: column j gets a chain of j+1 registers.
  for (genvar j = 0; j < int'(COLS); j++) begin : g_w_lane
    logic [INWIDTH-1:0] head;
    logic [INWIDTH-1:0] chain_q [j+1];

    // Non-accepted cycles inject zeros so bubbles stay aligned and multiply to nothing.
    assign head = accept ? in_w[j] : '0;

    // Shift the lane one stage per cycle.
    always_ff @(posedge clk) begin
      for (int k = 0; k <= j; k++) begin
        if (rst) begin
          chain_q[k] <= '0;
        end else if (k == 0) begin
          chain_q[k] <= head;
        end else begin
          chain_q[k] <= chain_q[(k >= 1) ? k - 1 : 0];
        end
      end
    end

    assign out_w[j] = chain_q[j];
  end

  // Activation lanes: row i gets a chain of i+1 registers.
  for (genvar i = 0; i < int'(ROWS); i++) begin : g_a_lane
    logic [INWIDTH-1:0] head;
    logic [INWIDTH-1:0] chain_q [i+1];

    assign head = accept ? in_a[i] : '0;

    // Shift the lane one stage per cycle.
    always_ff @(posedge clk) begin
      for (int k = 0; k <= i; k++) begin
        if (rst) begin
          chain_q[k] <= '0;
        end else if (k == 0) begin
          chain_q[k] <= head;
        end else begin
          chain_q[k] <= chain_q[(k >= 1) ? k - 1 : 0];
        end
      end
    end

    assign out_a[i] = chain_q[i];
  end

endmodule

// File: doc/sa_skew_feeder.md
# sa_skew_feeder

Input staging stage for the systolic PE array. Accepts one weight vector (one lane per array column) and one activation vector (one lane per array row) per handshake beat. Applies the diagonal skew the array needs: lane n is delayed n cycles relative to lane 0. Drives the top-left fire input, flushes the skew pipeline with zeros, and reports completion of each K-deep operand stream.

## Interface

Parameters:
- ROWS, 8, PE array rows; number of activation lanes.
- COLS, 8, PE array columns; number of weight lanes.
- INWIDTH, 8, operand width in bits.
- CNTW, 16, width of the stream-length and beat counters.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a stream; sampled only in IDLE.
- k_len  input  CNTW  beats in the stream; sampled with start.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  feeder accepts a beat this cycle.
- in_w  input  COLS x INWIDTH  weight vector; lane j feeds column j.
- in_a  input  ROWS x INWIDTH  activation vector; lane i feeds row i.
- out_w  output  COLS x INWIDTH  skewed weights to the array top edge.
- out_a  output  ROWS x INWIDTH  skewed activations to the array left edge.
- fire  output  1  to the top-left PE fire input; high when lane 0 carries an accepted beat.
- busy  output  1  high from FEED entry through DONE.
- done  output  1  one-cycle completion pulse.

## Operation

- D = max(ROWS, COLS) - 1.
- Skew:
  - Weight lane j is a register chain of depth j+1; activation lane i is a chain of depth i+1.
  - Lane 0 latency is 1 cycle; lane n latency is n+1 cycles.
  - An accepted beat (in_valid && in_ready) loads in_w/in_a into the chain heads.
  - Any other cycle loads zeros into all heads. Bubbles therefore stay aligned across lanes and contribute zero products.
- Fire: a 1-bit register set to the beat-accept strobe. fire aligns exactly with out_w[0]/out_a[0] carrying real data.
- States:
  - IDLE: in_ready=0, busy=0.
    - start=1 with k_len>0: latch k_len into the beat counter and go to FEED.
    - start=1 with k_len=0: go to DONE.
  - FEED: in_ready=1. Each accepted beat decrements the counter. When the accepted beat is the last one (counter==1), go to FLUSH on the same edge. in_ready is low from the next cycle.
  - FLUSH: in_ready=0. Count D+1 cycles, then go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE; k_len is ignored except with an accepted start.
- in_w/in_a are ignored when no beat is accepted. No combinational path from in_valid to in_ready.
- Reset (rst=1 at an edge): state goes to IDLE, all chain registers and the counters clear to 0. Mid-stream data is discarded, with no done pulse.

## Timing

- Reset values: in_ready=0, out_w=0, out_a=0, fire=0, busy=0, done=0.
- start high in IDLE at edge c0: busy=1 and in_ready=1 from cycle c0+1.
- Beat accepted at edge t: fire=1 and out_x[0]=beat during cycle t+1. Lane n shows the beat during cycle t+n+1.
- Last beat accepted at edge tL:
  - FLUSH covers cycles tL+1 .. tL+D+1.
  - The last lane emits its final element in cycle tL+D+1.
  - done=1 in cycle tL+D+2; IDLE (busy=0) from tL+D+3.
- With no bubbles, a stream of K beats takes K + D + 2 cycles from FEED entry to the done cycle inclusive.
- k_len=0: start at edge c0 gives done=1 in cycle c0+1 and IDLE from c0+2. fire stays 0.
- Lanes not yet loaded in a stream output 0. Outputs return to all-zero after the flush.

## Test plan

ROWS=COLS=4, INWIDTH=8, so D=3, unless stated.

1. Reset: hold rst 3 cycles with random in_w/in_a/in_valid/start -> all outputs 0 throughout. First cycle after release still all 0.
2. Stream, no bubbles: start, k_len=3; beats b=0..2 with in_w[j]=16*b+j, in_a[i]=0x80+16*b+i, in_valid held high. Let t0 be the first accept edge:
   - out_w[0]=0x00,0x10,0x20 in cycles t0+1..t0+3.
   - out_w[3]=0x03,0x13,0x23 in cycles t0+4..t0+6.
   - fire high in cycles t0+1..t0+3.
   - done in cycle t0+7; busy low at t0+8.
3. Bubble: k_len=2, in_valid low for 2 cycles between beats ->
   - fire pattern 1,0,0,1.
   - every lane shows the same pattern shifted by its lane index, with zeros in the gaps.
   - done 5 cycles after the second accept.
4. Degenerate and ignored start: start with k_len=0 -> done pulse the next cycle, no fire, busy high 1 cycle. Separately, start pulses during FEED/FLUSH -> no effect on counters or timing.
5. Reset mid-FEED after 1 of 4 beats -> next cycle all outputs 0, state IDLE, no done. A fresh start then behaves as in scenario 2.
6. Asymmetric ROWS=2, COLS=5 (D=4), k_len=1 ->
   - out_a[1] carries the beat at t+2; out_w[4] carries it at t+5.
   - done at t+6.
